mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist.sv | 199 +++++++++++++++++++
 tb/tb_mem_bist.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_bist
//
// Memory built-in self test initiator for the req/gnt/rvalid single-port RAM
// protocol. A run writes NUM_WORDS words with pattern P(i) = SEED ^ i at byte
// addresses BASE_ADDR + 4*i, then reads every word back and compares it. At
// most one transaction is ever outstanding.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      start pulse, accepted only while idle or done
//   req_o        memory request
//   gnt_i        request granted
//   rvalid_i     response valid
//   addr_o       byte address of the current word
//   we_o         write enable
//   be_o         byte enables (all ones during a request)
//   wdata_o      write data
//   rdata_i      read data
//   busy_o       test running
//   done_o       test finished, sticky until the next start
//   pass_o       valid with done_o: 1 when no word mismatched
//   err_count_o  saturating mismatch count
//   fail_addr_o  address of the first mismatching word
// ---------------------------------------------------------------------------
module mem_bist #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           NUM_WORDS  = 256,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(32'hA5A5_5A5A)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  req_o,
    input  logic                  gnt_i,
    input  logic                  rvalid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    // Byte address of word i; the sum wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] i);
        logic [ADDR_WIDTH+1:0] offset;
        offset = {ADDR_WIDTH'(i), 2'b00};
        return BASE_ADDR + offset[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [15:0] i);
        return SEED ^ DATA_WIDTH'(i);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [15:0]             idx_q, idx_d;
    logic [15:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]   fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    busy_q, done_q, pass_q;
    logic                    start_ok, finish;
    logic                    load_wr, load_rd;

    // Next-state, index and result bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        fail_d   = fail_q;
        start_ok = 1'b0;
        finish   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d  = WR_REQ;
                    idx_d    = '0;
                    err_d    = '0;
                    fail_d   = '0;
                    start_ok = 1'b1;
                end
            end
            // rvalid_i is deliberately ignored in REQ states: a response
            // can only belong to a transaction that was already granted.
            WR_REQ: begin
                if (gnt_i) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (rvalid_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rvalid_i) begin
                    if (rdata_i != pattern_of(idx_q)) begin
                        err_d = sat_inc(err_q);
                        // The counter saturates and never returns to zero,
                        // so zero identifies the first mismatch of the run.
                        if (err_q == 16'd0) fail_d = addr_of(idx_q);
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and write data are registered once on entry to a request
    // state, so they stay stable until granted and hold afterwards.
    assign load_wr = (state_d == WR_REQ) && (state_q != WR_REQ);
    assign load_rd = (state_d == RD_REQ) && (state_q != RD_REQ);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            if (load_wr) begin
                addr_q  <= addr_of(idx_d);
                wdata_q <= pattern_of(idx_d);
            end else if (load_rd) begin
                addr_q  <= addr_of(idx_d);
            end
            if (start_ok) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end else if (finish) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                pass_q <= (err_d == 16'd0);
            end
        end
    end

    // Request strobes decode the registered state directly, so an
    // asynchronous reset removes a pending request in the same cycle.
    assign req_o       = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign we_o        = (state_q == WR_REQ);
    assign be_o        = req_o ? 4'b1111 : 4'b0000;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_q;

endmodule

// File: tb/tb_mem_bist.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_bist
//
// Directed bench for mem_bist. Instance a tests words at 0x100, instance b
// tests the address wrap at 0xFFFF_FFF8. Both are served by small memory
// responders driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni;

    logic        start_a, req_a, gnt_a, rvalid_a, we_a, busy_a, done_a, pass_a;
    logic [3:0]  be_a;
    logic [31:0] addr_a, wdata_a, rdata_a, fail_a;
    logic [15:0] err_a;

    logic        start_b, req_b, gnt_b, rvalid_b, we_b, busy_b, done_b, pass_b;
    logic [3:0]  be_b;
    logic [31:0] addr_b, wdata_b, rdata_b, fail_b;
    logic [15:0] err_b;

    mem_bist #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_0100),
        .NUM_WORDS(4), .SEED(32'hA5A5_5A5A)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_a),
        .req_o(req_a), .gnt_i(gnt_a), .rvalid_i(rvalid_a),
        .addr_o(addr_a), .we_o(we_a), .be_o(be_a), .wdata_o(wdata_a),
        .rdata_i(rdata_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_count_o(err_a), .fail_addr_o(fail_a)
    );

    mem_bist #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'hFFFF_FFF8),
        .NUM_WORDS(4), .SEED(32'hA5A5_5A5A)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_b),
        .req_o(req_b), .gnt_i(gnt_b), .rvalid_i(rvalid_b),
        .addr_o(addr_b), .we_o(we_b), .be_o(be_b), .wdata_o(wdata_b),
        .rdata_i(rdata_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_count_o(err_b), .fail_addr_o(fail_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- responder for instance a ----------------
    int          gmin = 0, gmax = 0, rmin = 0, rmax = 0;
    int          gcnt = 0, rcnt = 0;
    int          stuck = -1;
    int          hold_n = 0, viol_n = 0, rv_n = 0;
    logic [31:0] mem_a [16];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we [$];

    initial begin
        bit          pend;
        bit          trk;
        logic [31:0] p_addr, p_wdata, t_addr, t_wdata, off;
        logic        p_we, t_we;
        int          idx;
        pend = 0; trk = 0;
        p_addr = '0; p_wdata = '0; p_we = 0;
        t_addr = '0; t_wdata = '0; t_we = 0;
        gnt_a = 0; rvalid_a = 0; rdata_a = '0;
        forever begin
            @(negedge clk);
            gnt_a = 0;
            rvalid_a = 0;
            if (pend) begin
                if (rcnt == 0) begin
                    rvalid_a = 1;
                    rv_n++;
                    off = p_addr - 32'h100;
                    idx = int'(off[5:2]);
                    if (p_we) mem_a[idx] = p_wdata;
                    else rdata_a = (idx == stuck) ? 32'h0 : mem_a[idx];
                    pend = 0;
                    gcnt = int'($urandom_range(gmax, gmin));
                end else begin
                    rcnt--;
                end
            end else if (req_a) begin
                if (!trk) begin
                    trk = 1;
                    t_addr = addr_a; t_we = we_a; t_wdata = wdata_a;
                end else begin
                    hold_n++;
                    if (addr_a !== t_addr || we_a !== t_we || wdata_a !== t_wdata) viol_n++;
                end
                if (gcnt == 0) begin
                    gnt_a = 1;
                    pend = 1;
                    trk = 0;
                    p_addr = addr_a; p_we = we_a; p_wdata = wdata_a;
                    log_addr.push_back(addr_a);
                    log_data.push_back(wdata_a);
                    log_we.push_back(we_a);
                    rcnt = int'($urandom_range(rmax, rmin));
                end else begin
                    gcnt--;
                end
            end
        end
    end

    // ---------------- ideal responder for instance b ----------------
    logic [31:0] mem_b [8];
    logic [31:0] logb_addr [$];
    logic        logb_we [$];

    initial begin
        bit          pend;
        logic [31:0] p_addr, p_wdata, off;
        logic        p_we;
        pend = 0; p_addr = '0; p_wdata = '0; p_we = 0;
        gnt_b = 0; rvalid_b = 0; rdata_b = '0;
        forever begin
            @(negedge clk);
            gnt_b = 0;
            rvalid_b = 0;
            if (pend) begin
                rvalid_b = 1;
                off = p_addr - 32'hFFFF_FFF8;
                if (p_we) mem_b[off[4:2]] = p_wdata;
                else rdata_b = mem_b[off[4:2]];
                pend = 0;
            end else if (req_b) begin
                gnt_b = 1;
                pend = 1;
                p_addr = addr_b; p_we = we_b; p_wdata = wdata_b;
                logb_addr.push_back(addr_b);
                logb_we.push_back(we_b);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_start_a();
        start_a = 1;
        @(negedge clk);
        start_a = 0;
    endtask

    task automatic wait_done_a(input int limit, output int cyc);
        cyc = 0;
        while (done_a !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    task automatic check_pattern(input string tag);
        check_eq({tag, "_nlog"}, log_addr.size(), 8);
        if (log_addr.size() == 8) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("%s_wa%0d", tag, i), log_addr[i], 32'h100 + 32'(4 * i));
                check_eq($sformatf("%s_wd%0d", tag, i), log_data[i], 32'hA5A5_5A5A ^ 32'(i));
                check_eq($sformatf("%s_we%0d", tag, i), {31'b0, log_we[i]}, 1);
                check_eq($sformatf("%s_ra%0d", tag, i), log_addr[4 + i], 32'h100 + 32'(4 * i));
                check_eq($sformatf("%s_rwe%0d", tag, i), {31'b0, log_we[4 + i]}, 0);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int rv_before;
        int lim;
        logic [31:0] exp_wrap [4];
        rst_ni = 0;
        start_a = 0;
        start_b = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_req", {31'b0, req_a}, 0);
        check_eq("rst_we", {31'b0, we_a}, 0);
        check_eq("rst_be", {28'b0, be_a}, 0);
        check_eq("rst_addr", addr_a, 0);
        check_eq("rst_wdata", wdata_a, 0);
        check_eq("rst_busy", {31'b0, busy_a}, 0);
        check_eq("rst_done", {31'b0, done_a}, 0);
        check_eq("rst_pass", {31'b0, pass_a}, 0);
        check_eq("rst_err", {16'b0, err_a}, 0);
        check_eq("rst_fail", fail_a, 0);
        rst_ni = 1;
        @(negedge clk);

        // Ideal memory: 16 cycles, pattern and addresses
        clear_log();
        pulse_start_a();
        check_eq("ideal_busy", {31'b0, busy_a}, 1);
        check_eq("ideal_be", {28'b0, be_a}, 32'hF);
        wait_done_a(100, cyc);
        check_eq("ideal_cycles", cyc, 16);
        check_eq("ideal_pass", {31'b0, pass_a}, 1);
        check_eq("ideal_err", {16'b0, err_a}, 0);
        check_eq("ideal_busy_end", {31'b0, busy_a}, 0);
        check_eq("ideal_addr_hold", addr_a, 32'h10C);
        check_eq("ideal_req_idle", {31'b0, req_a}, 0);
        check_pattern("ideal");

        // start while busy is ignored
        clear_log();
        pulse_start_a();
        repeat (5) @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        wait_done_a(100, cyc);
        check_eq("busy_start_cycles", 6 + cyc, 16);
        check_eq("busy_start_pass", {31'b0, pass_a}, 1);
        check_pattern("busy_start");

        // Word 2 stuck at zero
        stuck = 2;
        pulse_start_a();
        wait_done_a(100, cyc);
        check_eq("stuck_done", {31'b0, done_a}, 1);
        check_eq("stuck_pass", {31'b0, pass_a}, 0);
        check_eq("stuck_err", {16'b0, err_a}, 1);
        check_eq("stuck_fail_addr", fail_a, 32'h108);

        // Restart from DONE clears the result
        stuck = -1;
        pulse_start_a();
        check_eq("restart_err", {16'b0, err_a}, 0);
        check_eq("restart_fail", fail_a, 0);
        check_eq("restart_done", {31'b0, done_a}, 0);
        check_eq("restart_pass", {31'b0, pass_a}, 0);
        check_eq("restart_busy", {31'b0, busy_a}, 1);
        wait_done_a(100, cyc);
        check_eq("restart_cycles", cyc, 16);
        check_eq("restart_pass_end", {31'b0, pass_a}, 1);

        // Random grant / response delays
        gmin = 0; gmax = 5; rmin = 0; rmax = 5;
        gcnt = 3;
        hold_n = 0; viol_n = 0;
        clear_log();
        pulse_start_a();
        wait_done_a(2000, cyc);
        check_eq("rnd_done", {31'b0, done_a}, 1);
        check_eq("rnd_pass", {31'b0, pass_a}, 1);
        check_eq("rnd_err", {16'b0, err_a}, 0);
        check_eq("rnd_stable_viol", viol_n, 0);
        check_eq("rnd_holds_seen", {31'b0, hold_n > 0}, 1);
        check_pattern("rnd");

        // Reset during RD_WAIT of word 1, then a late response
        gmin = 0; gmax = 0; rmin = 4; rmax = 4;
        gcnt = 0;
        clear_log();
        pulse_start_a();
        lim = 0;
        while (log_addr.size() < 6 && lim < 300) begin
            @(negedge clk);
            lim++;
        end
        check_eq("rst_reach_rd1", {31'b0, log_addr.size() >= 6}, 1);
        @(negedge clk);
        check_eq("rst_pre_busy", {31'b0, busy_a}, 1);
        rst_ni = 0;
        #1;
        check_eq("rstmid_req", {31'b0, req_a}, 0);
        check_eq("rstmid_busy", {31'b0, busy_a}, 0);
        check_eq("rstmid_err", {16'b0, err_a}, 0);
        check_eq("rstmid_addr", addr_a, 0);
        rv_before = rv_n;
        @(negedge clk);
        rst_ni = 1;
        repeat (8) @(negedge clk);
        check_eq("late_rv_sent", rv_n - rv_before, 1);
        check_eq("late_busy", {31'b0, busy_a}, 0);
        check_eq("late_done", {31'b0, done_a}, 0);
        check_eq("late_err", {16'b0, err_a}, 0);
        check_eq("late_req", {31'b0, req_a}, 0);
        rmin = 0; rmax = 0;
        gcnt = 0;
        pulse_start_a();
        wait_done_a(100, cyc);
        check_eq("after_rst_cycles", cyc, 16);
        check_eq("after_rst_pass", {31'b0, pass_a}, 1);
        check_eq("after_rst_err", {16'b0, err_a}, 0);

        // Address wrap-around on instance b
        exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        start_b = 1;
        @(negedge clk);
        start_b = 0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("wrap_cycles", cyc, 16);
        check_eq("wrap_pass", {31'b0, pass_b}, 1);
        check_eq("wrap_err", {16'b0, err_b}, 0);
        check_eq("wrap_fail", fail_b, 0);
        check_eq("wrap_busy", {31'b0, busy_b}, 0);
        check_eq("wrap_be", {28'b0, be_b}, 0);
        check_eq("wrap_nlog", logb_addr.size(), 8);
        if (logb_addr.size() == 8) begin
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("wrap_wa%0d", i), logb_addr[i], exp_wrap[i]);
                check_eq($sformatf("wrap_we%0d", i), {31'b0, logb_we[i]}, 1);
                check_eq($sformatf("wrap_ra%0d", i), logb_addr[4 + i], exp_wrap[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
